// File: rtl/vga_halve_pkg.sv
// rtl/vga_halve_pkg.sv - shared types and page-selection helper for the scan halver
//
// Purpose: page index type, writer/reader state encodings, page count and the
//          free-page picker used when a new line capture begins.
// Ports:   none (package).
package vga_halve_pkg;

   typedef logic [1:0] page_t;

   typedef enum logic {W_IDLE, W_FILL} wr_state_t;
   typedef enum logic {R_IDLE, R_RUN} rd_state_t;

   localparam int NUM_PAGES = 3;

   // Lowest page index that is neither the published page nor the page being
   // replayed. With three pages and two protected ones, one is always free.
   function automatic page_t pick_free_page(input page_t rdy_pg, input page_t rd_pg);
      page_t pg;
      if (rdy_pg != 2'd0 && rd_pg != 2'd0) begin
         pg = 2'd0;
      end else if (rdy_pg != 2'd1 && rd_pg != 2'd1) begin
         pg = 2'd1;
      end else begin
         pg = 2'd2;
      end
      return pg;
   endfunction

endpackage

// File: rtl/vga_halve_ram.sv
// rtl/vga_halve_ram.sv - three-page line RAM, one write port, one registered read port
//
// Purpose: holds three line pages addressed as {page, ptr}; page 3 is never used.
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write strobe
//   wr_addr  in   {page, ptr} write address
//   wr_data  in   pixel to write
//   rd_addr  in   {page, ptr} read address
//   rd_data  out  pixel read, registered (one clk after rd_addr)
module vga_halve_ram
   import vga_halve_pkg::*;
#(
   parameter int PIX_W  = 6,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W+1:0] wr_addr,
   input  logic [PIX_W-1:0]  wr_data,
   input  logic [ADDR_W+1:0] rd_addr,
   output logic [PIX_W-1:0]  rd_data
);

   localparam int DEPTH = NUM_PAGES * (2 ** ADDR_W);

   logic [PIX_W-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/vga_halve.sv
// rtl/vga_halve.sv - scan halver: keeps one VGA line of each pair, replays it at half pixel rate
//
// Purpose: captures every other full-rate input line into a free page of a
//          triple-buffered line RAM and replays the most recently published
//          page over one TV line, each pixel held for two clocks.
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   line_start  in   1-clk pulse at start of each input line
//   pix_in      in   input pixel, valid the LINE_LEN clks after line_start
//   field_sel   in   parity of input lines to keep
//   out_start   in   1-clk pulse at start of each output line
//   pix_out     out  registered output pixel, 0 when blank
//   pix_valid   out  high while pix_out carries line data
module vga_halve
   import vga_halve_pkg::*;
#(
   parameter int LINE_LEN = 768,
   parameter int PIX_W    = 6,
   parameter int ADDR_W   = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             line_start,
   input  logic [PIX_W-1:0] pix_in,
   input  logic             field_sel,
   input  logic             out_start,
   output logic [PIX_W-1:0] pix_out,
   output logic             pix_valid
);

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LINE_LEN - 1);

   wr_state_t        wr_state_q, wr_state_d;
   rd_state_t        rd_state_q, rd_state_d;
   logic             parity_q, parity_d;
   logic             rdy_valid_q, rdy_valid_d;
   page_t            rdy_pg_q, rdy_pg_d;
   page_t            rd_pg_q, rd_pg_d;
   page_t            wr_pg_q, wr_pg_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic             phase_q, phase_d;
   logic             rd_vld_q, rd_vld_d;
   logic [PIX_W-1:0] pix_out_q, pix_out_d;
   logic             pix_valid_q, pix_valid_d;

   logic             wr_en;
   logic             publish;
   logic [PIX_W-1:0] rd_data;

   // Writer: line_start always wins, so a line_start mid-fill abandons the
   // partial page without publishing it and may immediately begin a new one.
   always_comb begin
      parity_d    = parity_q;
      wr_state_d  = wr_state_q;
      wr_ptr_d    = wr_ptr_q;
      wr_pg_d     = wr_pg_q;
      rdy_pg_d    = rdy_pg_q;
      rdy_valid_d = rdy_valid_q;
      wr_en       = 1'b0;
      publish     = 1'b0;
      if (line_start) begin
         parity_d = ~parity_q;
         if (parity_d == field_sel) begin
            wr_state_d = W_FILL;
            wr_ptr_d   = '0;
            wr_pg_d    = pick_free_page(rdy_pg_q, rd_pg_q);
         end else begin
            wr_state_d = W_IDLE;
         end
      end else if (wr_state_q == W_FILL) begin
         wr_en = 1'b1;
         if (wr_ptr_q == LAST) begin
            publish     = 1'b1;
            rdy_pg_d    = wr_pg_q;
            rdy_valid_d = 1'b1;
            wr_state_d  = W_IDLE;
         end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
      end
   end

   // Reader: a publish landing on the same clk as out_start is forwarded so
   // the new line is not missed for a whole output line.
   always_comb begin
      rd_state_d = rd_state_q;
      rd_ptr_d   = rd_ptr_q;
      rd_pg_d    = rd_pg_q;
      phase_d    = phase_q;
      if (out_start) begin
         phase_d = 1'b0;
         if (rdy_valid_q || publish) begin
            rd_state_d = R_RUN;
            rd_pg_d    = publish ? wr_pg_q : rdy_pg_q;
            rd_ptr_d   = '0;
         end else begin
            rd_state_d = R_IDLE;
         end
      end else if (rd_state_q == R_RUN) begin
         phase_d = ~phase_q;
         if (phase_q) begin
            if (rd_ptr_q == LAST) begin
               rd_state_d = R_IDLE;
            end else begin
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
         end
      end
   end

   // Two-stage output pipeline: RAM read register, then output register.
   always_comb begin
      rd_vld_d    = (rd_state_q == R_RUN);
      pix_valid_d = rd_vld_q;
      pix_out_d   = rd_vld_q ? rd_data : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_state_q  <= W_IDLE;
         rd_state_q  <= R_IDLE;
         parity_q    <= 1'b0;
         rdy_valid_q <= 1'b0;
         rdy_pg_q    <= 2'd0;
         rd_pg_q     <= 2'd0;
         wr_pg_q     <= 2'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         phase_q     <= 1'b0;
         rd_vld_q    <= 1'b0;
         pix_out_q   <= '0;
         pix_valid_q <= 1'b0;
      end else begin
         wr_state_q  <= wr_state_d;
         rd_state_q  <= rd_state_d;
         parity_q    <= parity_d;
         rdy_valid_q <= rdy_valid_d;
         rdy_pg_q    <= rdy_pg_d;
         rd_pg_q     <= rd_pg_d;
         wr_pg_q     <= wr_pg_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         phase_q     <= phase_d;
         rd_vld_q    <= rd_vld_d;
         pix_out_q   <= pix_out_d;
         pix_valid_q <= pix_valid_d;
      end
   end

   vga_halve_ram #(
      .PIX_W  (PIX_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr ({wr_pg_q, wr_ptr_q}),
      .wr_data (pix_in),
      .rd_addr ({rd_pg_q, rd_ptr_q}),
      .rd_data (rd_data)
   );

   assign pix_out   = pix_out_q;
   assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_vga_halve.sv
// tb/tb_vga_halve.sv - directed self-checking bench for the scan halver
module tb_vga_halve;
   import vga_halve_pkg::*;

   localparam int LINE_LEN = 768;
   localparam int PIX_W    = 6;
   localparam int ADDR_W   = 10;
   localparam int SAMPLES  = 2 * LINE_LEN + 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             line_start = 1'b0;
   logic [PIX_W-1:0] pix_in = '0;
   logic             field_sel = 1'b0;
   logic             out_start = 1'b0;
   logic [PIX_W-1:0] pix_out;
   logic             pix_valid;

   int vectors = 0;
   int miscompares = 0;
   int collisions = 0;

   vga_halve #(
      .LINE_LEN (LINE_LEN),
      .PIX_W    (PIX_W),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .line_start (line_start),
      .pix_in     (pix_in),
      .field_sel  (field_sel),
      .out_start  (out_start),
      .pix_out    (pix_out),
      .pix_valid  (pix_valid)
   );

   always #5 clk = ~clk;

   // The page being filled must never be the page being replayed.
   always @(negedge clk) begin
      if (rst_n && dut.wr_state_q == W_FILL && dut.wr_pg_q == dut.rd_pg_q) begin
         collisions++;
      end
   end

   function automatic logic [PIX_W-1:0] pat(input int seed, input int i);
      return PIX_W'((i + seed * 11) & 63);
   endfunction

   task automatic check(input string tag, input logic [PIX_W-1:0] op, input logic ov,
                        input logic [PIX_W-1:0] ep, input logic ev);
      vectors++;
      assert (op === ep && ov === ev) else begin
         miscompares++;
         $error("FAIL %s: pix_out=%0h pix_valid=%0b, expected pix_out=%0h pix_valid=%0b",
                tag, op, ov, ep, ev);
      end
   endtask

   // Starts at a negedge; ends at the negedge after the last pixel.
   task automatic drive_line(input int seed, input int npix, input bit os_last);
      line_start = 1'b1;
      @(negedge clk);
      line_start = 1'b0;
      for (int i = 0; i < npix; i++) begin
         pix_in = pat(seed, i);
         if (os_last && i == npix - 1) out_start = 1'b1;
         @(negedge clk);
      end
      out_start = 1'b0;
      pix_in    = '0;
   endtask

   task automatic pulse_out();
      out_start = 1'b1;
      @(negedge clk);
      out_start = 1'b0;
   endtask

   // Called at the negedge just after the edge that sampled out_start.
   task automatic sample_line(input string tag, input int seed, input bit blank);
      logic             ev;
      logic [PIX_W-1:0] ep;
      for (int j = 0; j < SAMPLES; j++) begin
         ev = !blank && j >= 2 && j < 2 * LINE_LEN + 2;
         ep = ev ? pat(seed, (j - 2) / 2) : '0;
         check(tag, pix_out, pix_valid, ep, ev);
         @(negedge clk);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_held", pix_out, pix_valid, 6'd0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_released", pix_out, pix_valid, 6'd0, 1'b0);

      // Nothing captured yet: output stays blank.
      pulse_out();
      sample_line("no_capture", 0, 1'b1);

      // Keep odd lines: ramp is captured, the following line is dropped.
      field_sel = 1'b1;
      drive_line(0, LINE_LEN, 1'b0);
      repeat (20) @(negedge clk);
      drive_line(5, LINE_LEN, 1'b0);
      repeat (20) @(negedge clk);
      pulse_out();
      sample_line("ramp", 0, 1'b0);

      // Continuous 1000-clk input lines, output lines every 2000 clks.
      fork
         begin
            for (int n = 0; n < 6; n++) begin
               drive_line(10 + n, LINE_LEN, 1'b0);
               repeat (1000 - 1 - LINE_LEN) @(negedge clk);
            end
         end
         begin
            repeat (1000) @(negedge clk);
            for (int k = 0; k < 3; k++) begin
               pulse_out();
               sample_line("stream", 10 + 2 * k, 1'b0);
               repeat (2000 - 1 - SAMPLES) @(negedge clk);
            end
         end
      join

      // Aborted capture leaves the previously published page in place.
      drive_line(20, LINE_LEN, 1'b0);
      repeat (20) @(negedge clk);
      drive_line(21, LINE_LEN, 1'b0);
      repeat (20) @(negedge clk);
      drive_line(22, 300, 1'b0);
      drive_line(23, LINE_LEN, 1'b0);
      repeat (20) @(negedge clk);
      pulse_out();
      sample_line("abort", 20, 1'b0);

      // out_start on the publish edge picks up the new page.
      repeat (20) @(negedge clk);
      drive_line(30, LINE_LEN, 1'b1);
      sample_line("publish_same_cycle", 30, 1'b0);

      // No new publish: the last line repeats.
      repeat (10) @(negedge clk);
      pulse_out();
      sample_line("repeat", 30, 1'b0);

      // Reset during replay clears the outputs without a clock edge.
      pulse_out();
      repeat (100) @(negedge clk);
      check("pre_reset", pix_out, pix_valid, pat(30, 49), 1'b1);
      #1 rst_n = 1'b0;
      #1 check("async_reset", pix_out, pix_valid, 6'd0, 1'b0);
      @(negedge clk);
      check("reset_low", pix_out, pix_valid, 6'd0, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      pulse_out();
      sample_line("post_reset_blank", 0, 1'b1);

      vectors++;
      assert (collisions === 0) else begin
         miscompares++;
         $error("FAIL page_collision: count=%0d, expected 0", collisions);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
